// File: rtl/pc_fetch_sequencer.sv
// PC register and instruction-fetch sequencer for the multicycle MIPS core.
// Drives the imem request/ack handshake, presents one instruction at a time
// to decode, and applies exception > branch > jump redirects.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        exception,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc
);

    localparam int unsigned AW = 32;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   pc_nxt, instr_nxt, instr_pc_nxt;
    logic            instr_valid_nxt;
    logic            pend_valid, pend_valid_nxt;
    logic            pend_exc, pend_exc_nxt;
    logic [AW-1:0]   pend_addr, pend_addr_nxt;

    logic            redir;
    logic [AW-1:0]   redir_tgt;
    logic            pend_exc_locked;

    // Handshake outputs decode only from registered state
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;

    // Prioritised redirect target, word aligned
    always_comb begin
        redir     = exception | branch_taken | jump;
        redir_tgt = RESET_VECTOR;
        if (exception)         redir_tgt = EXC_VECTOR;
        else if (branch_taken) redir_tgt = branch_target;
        else if (jump)         redir_tgt = jump_target;
        redir_tgt = {redir_tgt[AW-1:2], 2'b00};
    end

    // A pending exception outranks any later branch or jump
    assign pend_exc_locked = pend_valid & pend_exc & ~exception;

    // Next-state and datapath update
    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        instr_nxt       = instr;
        instr_pc_nxt    = instr_pc;
        instr_valid_nxt = instr_valid;
        pend_valid_nxt  = pend_valid;
        pend_exc_nxt    = pend_exc;
        pend_addr_nxt   = pend_addr;

        case (state)
            S_BOOT: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack) begin
                    pend_valid_nxt = 1'b0;
                    pend_exc_nxt   = 1'b0;
                    if (pend_exc_locked) begin
                        pc_nxt = pend_addr;
                    end else if (redir) begin
                        pc_nxt = redir_tgt;
                    end else if (pend_valid) begin
                        pc_nxt = pend_addr;
                    end else begin
                        instr_nxt       = imem_rdata;
                        instr_pc_nxt    = pc;
                        instr_valid_nxt = 1'b1;
                        pc_nxt          = pc + AW'(4);
                        state_nxt       = S_HOLD;
                    end
                end else if (redir && !pend_exc_locked) begin
                    pend_valid_nxt = 1'b1;
                    pend_exc_nxt   = exception;
                    pend_addr_nxt  = redir_tgt;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    instr_valid_nxt = 1'b0;
                    pc_nxt          = redir_tgt;
                    state_nxt       = S_FETCH;
                end else if (!stall) begin
                    instr_valid_nxt = 1'b0;
                    state_nxt       = S_FETCH;
                end
            end
            default: begin
                state_nxt = S_BOOT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_BOOT;
            pc          <= RESET_VECTOR;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            pend_valid  <= 1'b0;
            pend_exc    <= 1'b0;
            pend_addr   <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
            instr_valid <= instr_valid_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_exc    <= pend_exc_nxt;
            pend_addr   <= pend_addr_nxt;
        end
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed testbench for pc_fetch_sequencer: inputs driven and outputs
// sampled on the falling edge.
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        stall;
    logic        exception;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .exception    (exception),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc           (pc)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
        exception = 1'b0; branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0;
        tick(); tick();
        check_eq("rst_req", 32'(imem_req), 32'd0);
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'h0);

        // Boot cycle, then ack in first fetch cycle
        reset = 1'b0;
        check_eq("boot_req", 32'(imem_req), 32'd0);
        tick();
        check_eq("f0_req", 32'(imem_req), 32'd1);
        check_eq("f0_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        tick();
        imem_ack = 1'b0;
        check_eq("f0_valid", 32'(instr_valid), 32'd1);
        check_eq("f0_instr", instr, 32'h2008_0005);
        check_eq("f0_ipc", instr_pc, 32'h0);
        check_eq("f0_hold_req", 32'(imem_req), 32'd0);
        tick();
        check_eq("f1_req", 32'(imem_req), 32'd1);
        check_eq("f1_addr", imem_addr, 32'h4);
        check_eq("f1_valid", 32'(instr_valid), 32'd0);

        // Ack delayed 3 cycles: request held stable for 4 cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("dly_req", 32'(imem_req), 32'd1);
            check_eq("dly_addr", imem_addr, 32'h4);
        end
        imem_ack = 1'b1; imem_rdata = 32'hAAAA_0001; stall = 1'b1;
        tick();
        imem_ack = 1'b0;
        check_eq("dly_ipc", instr_pc, 32'h4);
        check_eq("dly_pc", pc, 32'h8);

        // Stall held 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stl_valid", 32'(instr_valid), 32'd1);
            check_eq("stl_instr", instr, 32'hAAAA_0001);
            check_eq("stl_req", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        check_eq("stl_rel_req", 32'(imem_req), 32'd1);
        check_eq("stl_rel_addr", imem_addr, 32'h8);

        // Branch during pending fetch at 0x8; word discarded
        branch_taken = 1'b1; branch_target = 32'h0000_0103;
        tick();
        branch_taken = 1'b0;
        check_eq("br_addr_hold", imem_addr, 32'h8);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'hBBBB_BBBB;
        tick();
        imem_ack = 1'b0;
        check_eq("br_valid", 32'(instr_valid), 32'd0);
        check_eq("br_req", 32'(imem_req), 32'd1);
        check_eq("br_addr", imem_addr, 32'h100);
        check_eq("br_instr", instr, 32'hAAAA_0001);

        // All three redirects with ack in same cycle
        exception = 1'b1; branch_taken = 1'b1; branch_target = 32'h200;
        jump = 1'b1; jump_target = 32'h300; imem_ack = 1'b1;
        tick();
        exception = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_ack = 1'b0;
        check_eq("pri_pc", pc, 32'h80);
        check_eq("pri_valid", 32'(instr_valid), 32'd0);

        // Pending exception not overwritten by later jump
        exception = 1'b1;
        tick();
        exception = 1'b0; jump = 1'b1; jump_target = 32'h300;
        tick();
        jump = 1'b0; imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check_eq("pexc_pc", pc, 32'h80);
        check_eq("pexc_valid", 32'(instr_valid), 32'd0);

        // Fetch at 0x80, then flush in HOLD under stall
        imem_ack = 1'b1; imem_rdata = 32'hCCCC_0080;
        tick();
        imem_ack = 1'b0;
        check_eq("h_instr", instr, 32'hCCCC_0080);
        check_eq("h_pc", pc, 32'h84);
        stall = 1'b1; jump = 1'b1; jump_target = 32'h300;
        tick();
        stall = 1'b0; jump = 1'b0;
        check_eq("flush_valid", 32'(instr_valid), 32'd0);
        check_eq("flush_addr", imem_addr, 32'h300);
        check_eq("flush_req", 32'(imem_req), 32'd1);

        // PC wrap from 0xFFFF_FFFC
        jump = 1'b1; jump_target = 32'hFFFF_FFFE; imem_ack = 1'b1;
        tick();
        jump = 1'b0;
        check_eq("wrap_pc0", pc, 32'hFFFF_FFFC);
        imem_rdata = 32'hDDDD_0001;
        tick();
        imem_ack = 1'b0;
        check_eq("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
        check_eq("wrap_pc", pc, 32'h0);
        tick();
        check_eq("wrap_addr", imem_addr, 32'h0);

        // Move to 0x40, then reset during fetch with late ack
        jump = 1'b1; jump_target = 32'h40; imem_ack = 1'b1;
        tick();
        jump = 1'b0; imem_ack = 1'b0;
        check_eq("pre_rst_pc", pc, 32'h40);
        reset = 1'b1;
        tick();
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        jump = 1'b1; jump_target = 32'h500;
        check_eq("mrst_req", 32'(imem_req), 32'd0);
        check_eq("mrst_pc", pc, 32'h0);
        check_eq("mrst_valid", 32'(instr_valid), 32'd0);
        tick();
        imem_ack = 1'b0; jump = 1'b0;
        check_eq("mrst_ack_valid", 32'(instr_valid), 32'd0);
        check_eq("mrst_ack_instr", instr, 32'h0);
        check_eq("mrst_ack_req", 32'(imem_req), 32'd1);
        check_eq("mrst_ack_addr", imem_addr, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
